// File: rtl/eq_coeff_controller_pkg.sv
// Shared types and constants for the equalizer coefficient controller.
// Coefficients are Q2.14; each band holds b0, b1, b2, a1, a2 in that order.
package eq_pkg;

  localparam int COEFF_W         = 16;
  localparam int NUM_BANDS       = 3;
  localparam int COEFFS_PER_BAND = 5;
  localparam int NUM_COEFFS      = NUM_BANDS * COEFFS_PER_BAND;
  localparam logic signed [COEFF_W-1:0] Q14_ONE = 16'sh4000;

  typedef enum logic [2:0] {B0, B1, B2, A1, A2} coeff_idx_e;

  typedef enum logic [1:0] {IDLE, CHECK, ARMED, COMMIT} eq_ctrl_state_e;

  // Passthrough biquad: b0 = 1.0, everything else zero.
  function automatic logic [COEFF_W-1:0] passthrough_coeff(input int idx);
    return ((idx % COEFFS_PER_BAND) == int'(B0)) ? Q14_ONE : '0;
  endfunction

  // Stability triangle test, widened by two bits so 1.0 + a2 cannot overflow.
  function automatic logic band_unstable(input logic [COEFF_W-1:0] a1,
                                         input logic [COEFF_W-1:0] a2);
    logic signed [COEFF_W+1:0] a1_x;
    logic signed [COEFF_W+1:0] a2_x;
    logic signed [COEFF_W+1:0] a1_abs;
    logic signed [COEFF_W+1:0] one_x;
    a1_x   = {{2{a1[COEFF_W-1]}}, a1};
    a2_x   = {{2{a2[COEFF_W-1]}}, a2};
    one_x  = {2'b00, Q14_ONE};
    a1_abs = a1_x[COEFF_W+1] ? -a1_x : a1_x;
    return (a2_x >= one_x) || (a2_x <= -one_x) || (a1_abs >= (one_x + a2_x));
  endfunction

endpackage

// File: rtl/eq_coeff_controller_if.sv
// Configuration write port and commit handshake between the MCU config receiver and the controller.
// commit_err is present only when EQ_STABILITY_CHECK_EN is defined.
interface eq_coeff_controller_if #(
  parameter int COEFF_W = eq_pkg::COEFF_W
);
  logic               cfg_valid;
  logic [3:0]         cfg_addr;
  logic [COEFF_W-1:0] cfg_data;
  logic               cfg_ready;
  logic               commit_req;
  logic               busy;
  logic               commit_done;
`ifdef EQ_STABILITY_CHECK_EN
  logic               commit_err;
`endif
  logic               addr_err;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, commit_req,
    input  cfg_ready, busy, commit_done,
`ifdef EQ_STABILITY_CHECK_EN
    input  commit_err,
`endif
    input  addr_err
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, commit_req,
    output cfg_ready, busy, commit_done,
`ifdef EQ_STABILITY_CHECK_EN
    output commit_err,
`endif
    output addr_err
  );

endinterface

// File: rtl/eq_coeff_controller_lr_edge_detect.sv
// Purpose: bring l_r_clk into the clk domain and flag every sample boundary (both edges).
// Latency: toggle to lr_edge in 2-3 clk edges. Backpressure: none, free-running.
module lr_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic l_r_clk,
  output logic lr_edge
);

  logic sync_meta;
  logic sync_out;
  logic sync_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= l_r_clk;
      sync_out  <= sync_meta;
      sync_prev <= sync_out;
    end
  end

  assign lr_edge = sync_out ^ sync_prev;

endmodule

// File: rtl/eq_coeff_controller.sv
// Purpose: shadow/active coefficient banks; commit copies shadow to active on an l_r_clk boundary. Optional EQ_STABILITY_CHECK_EN.
// Latency: write lands in shadow next edge; l_r_clk toggle to new coeff_out within 5 clk cycles.
// Backpressure: cfg_ready low outside IDLE, freezing the shadow bank while a commit is in flight.
module eq_coeff_controller #(
  parameter int NUM_BANDS = eq_pkg::NUM_BANDS,
  parameter int COEFF_W   = eq_pkg::COEFF_W
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  l_r_clk,
  eq_coeff_controller_if.slave                                  cfg,
  output logic [NUM_BANDS*eq_pkg::COEFFS_PER_BAND*COEFF_W-1:0]  coeff_out
);
  import eq_pkg::*;

  localparam int NC = NUM_BANDS * COEFFS_PER_BAND;
  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  typedef logic [COEFF_W-1:0] word_t;

  eq_ctrl_state_e state_q;
  eq_ctrl_state_e state_d;
  word_t          shadow_q [NC];
  word_t          active_q [NC];
  logic           lr_edge;
  logic           cfg_ready_c;
  logic           wr_fire;
  logic           wr_addr_ok;
  logic           commit_done_q;
  logic           addr_err_q;

  lr_edge_detect u_lr_edge (
    .clk     (clk),
    .reset   (reset),
    .l_r_clk (l_r_clk),
    .lr_edge (lr_edge)
  );

  assign wr_fire    = cfg.cfg_valid && cfg_ready_c;
  assign wr_addr_ok = (32'(cfg.cfg_addr) < NC);

`ifdef EQ_STABILITY_CHECK_EN
  logic [BW-1:0] band_cnt_q;
  logic          chk_fail_q;
  logic          band_bad;
  logic          last_band;
  logic          commit_err_q;
  word_t         chk_a1;
  word_t         chk_a2;

  always_comb begin
    chk_a1 = '0;
    chk_a2 = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (band_cnt_q == BW'(b)) begin
        chk_a1 = shadow_q[b*COEFFS_PER_BAND + int'(A1)];
        chk_a2 = shadow_q[b*COEFFS_PER_BAND + int'(A2)];
      end
    end
  end

  assign band_bad  = band_unstable(chk_a1, chk_a2);
  assign last_band = (band_cnt_q == BW'(NUM_BANDS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      band_cnt_q   <= '0;
      chk_fail_q   <= 1'b0;
      commit_err_q <= 1'b0;
    end else begin
      commit_err_q <= (state_q == CHECK) && last_band && (chk_fail_q || band_bad);
      if (state_q == CHECK) begin
        band_cnt_q <= band_cnt_q + 1'b1;
        chk_fail_q <= chk_fail_q | band_bad;
      end else begin
        band_cnt_q <= '0;
        chk_fail_q <= 1'b0;
      end
    end
  end

  assign cfg.commit_err = commit_err_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready_c = 1'b1;
        if (cfg.commit_req) begin
`ifdef EQ_STABILITY_CHECK_EN
          state_d = CHECK;
`else
          state_d = ARMED;
`endif
        end
      end
      CHECK: begin
`ifdef EQ_STABILITY_CHECK_EN
        if (last_band) begin
          state_d = (chk_fail_q || band_bad) ? IDLE : ARMED;
        end
`else
        state_d = IDLE;
`endif
      end
      ARMED: begin
        if (lr_edge) begin
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write and a commit request in the same IDLE cycle both land: the
  // shadow updates on this edge and the commit sees the new word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NC; i++) begin
        shadow_q[i] <= word_t'(passthrough_coeff(i));
        active_q[i] <= word_t'(passthrough_coeff(i));
      end
      commit_done_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      commit_done_q <= (state_q == COMMIT);
      addr_err_q    <= wr_fire && !wr_addr_ok;
      if (wr_fire && wr_addr_ok) begin
        shadow_q[cfg.cfg_addr] <= cfg.cfg_data;
      end
      if (state_q == COMMIT) begin
        for (int i = 0; i < NC; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  always_comb begin
    coeff_out = '0;
    for (int i = 0; i < NC; i++) begin
      coeff_out[i*COEFF_W +: COEFF_W] = active_q[i];
    end
  end

  assign cfg.cfg_ready   = cfg_ready_c;
  assign cfg.busy        = (state_q != IDLE);
  assign cfg.commit_done = commit_done_q;
  assign cfg.addr_err    = addr_err_q;

endmodule

// File: tb/tb_eq_coeff_controller.sv
// Randomized bench for eq_coeff_controller against an array-based model of the two banks.
// Build with EQ_STABILITY_CHECK_EN defined to also cover the stability rejection path.
module tb_eq_coeff_controller;
  import eq_pkg::*;

  localparam int NC = NUM_COEFFS;
  localparam int W  = NUM_COEFFS * COEFF_W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         l_r_clk = 1'b0;
  logic [W-1:0] coeff_out;

  eq_coeff_controller_if cfg_if ();

  eq_coeff_controller #(.NUM_BANDS(NUM_BANDS), .COEFF_W(COEFF_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .l_r_clk   (l_r_clk),
    .cfg       (cfg_if),
    .coeff_out (coeff_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_shadow [NC];
  logic [15:0] m_active [NC];

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_shadow[i] = (i % 5 == 0) ? 16'h4000 : 16'h0000;
      m_active[i] = m_shadow[i];
    end
  endfunction

  function automatic logic [W-1:0] pack_active();
    logic [W-1:0] v = '0;
    for (int i = 0; i < NC; i++) v[i*16 +: 16] = m_active[i];
    return v;
  endfunction

  function automatic bit model_bank_stable();
    bit ok = 1'b1;
    for (int b = 0; b < NUM_BANDS; b++) begin
      int a1 = int'($signed(m_shadow[b*5+3]));
      int a2 = int'($signed(m_shadow[b*5+4]));
      int a1_abs = (a1 < 0) ? -a1 : a1;
      if (a2 >= 16384 || a2 <= -16384 || a1_abs >= 16384 + a2) ok = 1'b0;
    end
    return ok;
  endfunction

  // Returns 1 when the model expects the commit to be applied.
  function automatic bit model_commit();
    bit ok = 1'b1;
`ifdef EQ_STABILITY_CHECK_EN
    ok = model_bank_stable();
`endif
    if (ok) for (int i = 0; i < NC; i++) m_active[i] = m_shadow[i];
    return ok;
  endfunction

  function automatic logic [15:0] rand_coeff(input int addr);
    if (addr % 5 >= 3) return 16'(int'($urandom_range(16000)) - 8000);
    return 16'($urandom);
  endfunction

  // Stimulus helpers: all called at a negedge, return at a negedge.
  task automatic wr(input logic [3:0] a, input logic [15:0] d, output logic ae);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = a;
    cfg_if.cfg_data  = d;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    ae = cfg_if.addr_err;
    if (a < 4'd15) m_shadow[a] = d;
  endtask

  task automatic commit_pulse(output int dn, output int er);
    dn = 0;
    er = 0;
    cfg_if.commit_req = 1'b1;
    @(negedge clk);
    cfg_if.commit_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (cfg_if.commit_done === 1'b1) dn++;
`ifdef EQ_STABILITY_CHECK_EN
      if (cfg_if.commit_err === 1'b1) er++;
`endif
      if (c < 5) @(negedge clk);
    end
  endtask

  task automatic toggle_wait(output int lat, output int dn);
    lat = -1;
    dn  = 0;
    l_r_clk = ~l_r_clk;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (cfg_if.commit_done === 1'b1) begin
        dn++;
        if (lat < 0) lat = c;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    vectors++;
    if (coeff_out !== pack_active()) begin
      miscompares++;
      $display("FAIL reset_coeff: got %h expected %h", coeff_out, pack_active());
    end
    vectors++;
    if (cfg_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", cfg_if.busy);
    end
    vectors++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", cfg_if.cfg_ready);
    end
    vectors++;
    if (cfg_if.commit_done !== 1'b0 || cfg_if.addr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: done %b addr_err %b expected 0 0", cfg_if.commit_done, cfg_if.addr_err);
    end
  endtask

  task automatic test_write_commit();
    logic ae;
    int dn, er, lat;
    wr(4'd5, 16'h2000, ae);
    commit_pulse(dn, er);
    vectors++;
    if (cfg_if.busy !== 1'b1 || dn != 0 || er != 0) begin
      miscompares++;
      $display("FAIL wc_armed: busy %b done %0d err %0d expected 1 0 0", cfg_if.busy, dn, er);
    end
    vectors++;
    if (coeff_out[5*16 +: 16] !== 16'h4000) begin
      miscompares++;
      $display("FAIL wc_before_edge: got %h expected 4000", coeff_out[5*16 +: 16]);
    end
    toggle_wait(lat, dn);
    void'(model_commit());
    vectors++;
    if (dn != 1 || lat < 1 || lat > 5) begin
      miscompares++;
      $display("FAIL wc_done: pulses %0d latency %0d expected 1 and 1..5", dn, lat);
    end
    vectors++;
    if (coeff_out[5*16 +: 16] !== 16'h2000 || coeff_out !== pack_active()) begin
      miscompares++;
      $display("FAIL wc_after_edge: got %h expected %h", coeff_out, pack_active());
    end
  endtask

  task automatic test_addr_err();
    logic ae;
    int dn, er, lat, pulses;
    wr(4'd15, 16'($urandom), ae);
    pulses = (ae === 1'b1) ? 1 : 0;
    repeat (2) begin
      @(negedge clk);
      if (cfg_if.addr_err === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL addr_err_pulse: got %0d pulses expected 1", pulses);
    end
    commit_pulse(dn, er);
    toggle_wait(lat, dn);
    void'(model_commit());
    vectors++;
    if (coeff_out !== pack_active()) begin
      miscompares++;
      $display("FAIL addr_err_shadow: got %h expected %h", coeff_out, pack_active());
    end
  endtask

  task automatic test_back_to_back();
    logic ae;
    int dn, er, lat, n, a;
    bit exp_ok;
    for (int it = 0; it < 10; it++) begin
      n = int'($urandom_range(6, 1));
      for (int k = 0; k < n; k++) begin
        a = int'($urandom_range(15));
        wr(4'(a), rand_coeff(a), ae);
        vectors++;
        if (ae !== (a == 15)) begin
          miscompares++;
          $display("FAIL b2b_addr_err: addr %0d got %b expected %b", a, ae, (a == 15));
        end
      end
      commit_pulse(dn, er);
      toggle_wait(lat, dn);
      exp_ok = model_commit();
      vectors++;
      if (dn != int'(exp_ok) || (exp_ok && lat > 5)) begin
        miscompares++;
        $display("FAIL b2b_done: pulses %0d latency %0d expected %0d pulse(s) within 5", dn, lat, exp_ok);
      end
      vectors++;
      if (coeff_out !== pack_active()) begin
        miscompares++;
        $display("FAIL b2b_coeff: got %h expected %h", coeff_out, pack_active());
      end
    end
  endtask

  task automatic test_stall();
    int dn, er, lat;
    bit acc;
    commit_pulse(dn, er);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = 4'd0;
    cfg_if.cfg_data  = 16'h1234;
    @(negedge clk);
    vectors++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_ready: got %b expected 0", cfg_if.cfg_ready);
    end
    l_r_clk = ~l_r_clk;
    acc = 1'b0;
    dn  = 0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk);
      if (cfg_if.commit_done === 1'b1) dn++;
      if (cfg_if.cfg_ready === 1'b1) begin
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        acc = 1'b1;
      end
    end
    cfg_if.cfg_valid = 1'b0;
    void'(model_commit());
    m_shadow[0] = 16'h1234;
    repeat (6) @(negedge clk);
    vectors++;
    if (!acc || dn != 1 || coeff_out !== pack_active()) begin
      miscompares++;
      $display("FAIL stall_commit: accepted %b done %0d coeff %h expected 1 1 %h", acc, dn, coeff_out, pack_active());
    end
    commit_pulse(dn, er);
    toggle_wait(lat, dn);
    void'(model_commit());
    vectors++;
    if (coeff_out[15:0] !== 16'h1234 || coeff_out !== pack_active()) begin
      miscompares++;
      $display("FAIL stall_recommit: got %h expected %h", coeff_out, pack_active());
    end
  endtask

`ifdef EQ_STABILITY_CHECK_EN
  task automatic test_stability();
    logic ae;
    int dn, er, lat, tot;
    bit exp_ok;
    logic [3:0]  t_addr [4] = '{4'd9, 4'd9, 4'd8, 4'd8};
    logic [15:0] t_val  [4] = '{16'h4000, 16'hC000, 16'hC000, 16'h3FFF};
    for (int t = 0; t < 4; t++) begin
      wr(4'd8, 16'h0000, ae);
      wr(4'd9, 16'h0000, ae);
      wr(t_addr[t], t_val[t], ae);
      exp_ok = model_bank_stable();
      commit_pulse(dn, er);
      vectors++;
      if (er != int'(!exp_ok) || cfg_if.busy !== exp_ok) begin
        miscompares++;
        $display("FAIL stab_err case %0d: err %0d busy %b expected %0d %b", t, er, cfg_if.busy, !exp_ok, exp_ok);
      end
      tot = 0;
      for (int e = 0; e < 3; e++) begin
        toggle_wait(lat, dn);
        tot += dn;
      end
      void'(model_commit());
      vectors++;
      if (tot != int'(exp_ok) || coeff_out !== pack_active()) begin
        miscompares++;
        $display("FAIL stab_commit case %0d: done %0d coeff %h expected %0d %h", t, tot, coeff_out, exp_ok, pack_active());
      end
    end
    wr(4'd8, 16'h0000, ae);
  endtask
`endif

  task automatic test_reset_mid();
    logic ae;
    int dn, er, lat;
    wr(4'd2, 16'h0777, ae);
    commit_pulse(dn, er);
    vectors++;
    if (cfg_if.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_armed: busy %b expected 1", cfg_if.busy);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    vectors++;
    if (coeff_out !== pack_active() || cfg_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_reset: coeff %h busy %b expected %h 0", coeff_out, cfg_if.busy, pack_active());
    end
    repeat (4) @(negedge clk);
    toggle_wait(lat, dn);
    vectors++;
    if (dn != 0 || coeff_out !== pack_active()) begin
      miscompares++;
      $display("FAIL rmid_no_commit: done %0d coeff %h expected 0 %h", dn, coeff_out, pack_active());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_addr   = 4'd0;
    cfg_if.cfg_data   = 16'h0000;
    cfg_if.commit_req = 1'b0;
    model_reset();
    test_reset();
    test_write_commit();
    test_addr_err();
    test_back_to_back();
    test_stall();
`ifdef EQ_STABILITY_CHECK_EN
    test_stability();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eq_coeff_controller.md
# eq_coeff_controller

Run-time coefficient manager for the three cascaded biquad bands of the equalizer. It holds a shadow bank written one 16-bit word at a time by the MCU-side configuration receiver. On a commit request it copies the whole bank into an active bank, and it does that only at an `l_r_clk` sample boundary, so no band ever runs a sample with a mix of old and new coefficients. It sits between the configuration receiver and the coefficient inputs of the three `iir_time_mux_accum` instances.

## Interface
- `NUM_BANDS`, default 3: number of biquad bands.
- `COEFF_W`, default 16: coefficient width, Q2.14 signed.
- `clk` in 1: high-speed system clock; the only clock.
- `reset` in 1: synchronous, active-low.
- `l_r_clk` in 1: left/right select; every edge is a sample boundary; asynchronous to `clk`.
- `cfg_valid` in 1: write request.
- `cfg_addr` in 4: coefficient index = band*5 + k, with k = 0 b0, 1 b1, 2 b2, 3 a1, 4 a2. Low band is band 0, mid is 1, high is 2.
- `cfg_data` in 16: coefficient value, Q2.14.
- `cfg_ready` out 1: write accepted when `cfg_valid && cfg_ready`.
- `commit_req` in 1: single-cycle request to apply the shadow bank.
- `busy` out 1: a commit is in progress; high in CHECK, ARMED and COMMIT.
- `commit_done` out 1: one-cycle pulse when the active bank has been updated.
- `commit_err` out 1: one-cycle pulse when a commit is rejected. Exists only with the macro.
- `addr_err` out 1: one-cycle pulse on an accepted write to address 15.
- `coeff_out` out 240: active bank, flattened. Index i occupies bits [16i+15:16i].

## Operation
- Reset, in the cycle `reset == 0`:
  - Both banks load passthrough values: every b0 = 16'sh4000, every other coefficient = 0.
  - FSM goes to IDLE and any pending commit is discarded.
  - `busy`, `commit_done`, `commit_err` and `addr_err` are 0; `cfg_ready` is 1 once out of reset.
- Edge detect:
  - `l_r_clk` passes through a 2-flop synchronizer, then a previous-value register.
  - `lr_edge` = sync output XOR previous value. Both rising and falling edges count.
- FSM states: IDLE, CHECK, ARMED, COMMIT.
  - IDLE: `cfg_ready` = 1. Accepted writes with address 0–14 update the shadow word. A write to address 15 is dropped and pulses `addr_err`.
  - IDLE + `commit_req`: go to CHECK if the macro is defined, otherwise to ARMED.
  - IDLE, `cfg_valid` and `commit_req` in the same cycle: the write is applied first, and the commit uses the updated shadow bank.
  - CHECK: described under Configuration.
  - ARMED: `cfg_ready` = 0, so writes stall and the shadow bank is frozen. Waits for `lr_edge`, then goes to COMMIT.
  - COMMIT, one cycle: active bank <= shadow bank, `commit_done` pulses, FSM returns to IDLE.
- `commit_req` outside IDLE is ignored; it is not queued.
- The active bank changes only in COMMIT or on reset.
- `coeff_out` is registered; there is no combinational path from `cfg_*` to it.
- Shadow contents persist after a commit. A later commit with no new writes re-applies the same values.

## Timing
- Write: the shadow register updates on the clock edge where `cfg_valid && cfg_ready`. One word per cycle is sustained in IDLE.
- `l_r_clk` toggle to `lr_edge` asserted: 3 `clk` cycles.
- `lr_edge` in ARMED to COMMIT: 1 cycle.
- COMMIT to new `coeff_out`: 1 cycle. `commit_done` is high in that same cycle.
- Total, `l_r_clk` toggle to new `coeff_out`: at most 5 `clk` cycles. After that `coeff_out` is stable for the rest of the sample period.
- `lr_edge` in IDLE or CHECK has no effect. If CHECK passes, ARMED waits for the following edge.
- Worst case from `commit_req` to `commit_done`: 3 + one `l_r_clk` half-period + 5 cycles.
- Reset mid-ARMED: the commit is dropped, no `commit_done` pulse, and the active bank returns to passthrough.

## Configuration
- Macro `EQ_STABILITY_CHECK_EN`.
- Defined:
  - CHECK scans one band per cycle for `NUM_BANDS` cycles.
  - A band fails if a2 >= 16'sh4000 or a2 <= -16'sh4000 (|a2| >= 1.0), or if |a1| >= 1.0 + a2, evaluated in 18-bit signed arithmetic.
  - Any failure: pulse `commit_err` in the cycle after the last band, return to IDLE, and leave the active bank unchanged.
  - All bands pass: go to ARMED.
- Undefined: CHECK is removed, IDLE goes straight to ARMED, and `commit_err` is absent.

## Structure
- Package `eq_pkg` holds:
  - `COEFF_W`, `NUM_BANDS`, `COEFFS_PER_BAND` = 5, `NUM_COEFFS` = 15, `Q14_ONE` = 16'sh4000;
  - enum `coeff_idx_e` (B0, B1, B2, A1, A2);
  - FSM state enum `eq_ctrl_state_e`.
- Sub-module `lr_edge_detect`: 2-flop synchronizer plus any-edge pulse. It is reused wherever `l_r_clk` boundaries are needed.

## Test plan
- Reset: hold `reset = 0` for 2 cycles → `coeff_out` has indices 0, 5, 10 = 16'sh4000 and all others 0; `busy = 0`; `cfg_ready = 1`.
- Write then commit:
  - Write index 5 = 16'sh2000, then `commit_req`.
  - Before the next `l_r_clk` toggle: index 5 still 16'sh4000.
  - At most 5 cycles after the toggle: index 5 = 16'sh2000, with one `commit_done` pulse.
- Stall: in ARMED assert `cfg_valid` with index 0 = 16'sh1234 → `cfg_ready = 0`. The write is accepted after COMMIT and appears only after the next commit.
- Address error: write to address 15 → `addr_err` pulses once; the shadow bank is unchanged.
- Macro defined, unstable a2: write index 9 (mid a2) = 16'sh4000 and commit → `commit_err` pulses, no `commit_done` even across 3 `l_r_clk` edges, active bank unchanged.
- Reset mid-operation: `commit_req`, then drop `reset` while ARMED → passthrough `coeff_out`; a subsequent `l_r_clk` edge produces no `commit_done`.
